// File: rtl/anti_theft_pkg.sv
// Shared encodings for the anti-theft timer path: interval selects and timer FSM states.
package anti_theft_pkg;

  localparam logic [1:0] INTERVAL_ARM_DELAY       = 2'b00;
  localparam logic [1:0] INTERVAL_DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] INTERVAL_PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] INTERVAL_ALARM_ON        = 2'b11;

  localparam logic [1:0] TIMER_ST_IDLE   = 2'd0;
  localparam logic [1:0] TIMER_ST_FETCH  = 2'd1;
  localparam logic [1:0] TIMER_ST_COUNT  = 2'd2;
  localparam logic [1:0] TIMER_ST_EXPIRE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = TIMER_ST_IDLE,
    ST_FETCH  = TIMER_ST_FETCH,
    ST_COUNT  = TIMER_ST_COUNT,
    ST_EXPIRE = TIMER_ST_EXPIRE
  } timer_state_e;

endpackage

// File: rtl/anti_theft_interval_timer_tick_prescaler.sv
// Divides the system clock down to a one-second terminal-count pulse (TICK_DIV cycles).
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign terminal = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/anti_theft_interval_timer.sv
// Interval timer: fetches a seconds value from the parameter store and counts it down.
// Optional TIMER_REMAINING_EN exposes the live seconds-left count on port remaining.
module anti_theft_interval_timer
  import anti_theft_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int VALUE_W  = 4
) (
  input  logic               clock,
  input  logic               systemResetN,
  input  logic               startTimer,
  input  logic [1:0]         intervalIn,
  output logic [1:0]         paramSel,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               tick,
  output logic               expired
`ifdef TIMER_REMAINING_EN
  ,
  output logic [VALUE_W-1:0] remaining
`endif
);

  timer_state_e       state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [VALUE_W-1:0] rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               tick_q, tick_d;
  logic               expired_q, expired_d;
  logic               presc_clear, presc_en, presc_tc;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk     (clock),
    .rst_n   (systemResetN),
    .clear   (presc_clear),
    .enable  (presc_en),
    .terminal(presc_tc)
  );

  assign presc_en = (state_q == ST_COUNT);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rem_d       = rem_q;
    tick_d      = 1'b0;
    presc_clear = 1'b1;

    // A start request wins over everything else in any state: re-latch and refetch.
    if (startTimer) begin
      sel_d   = intervalIn;
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          rem_d   = value;
          state_d = (value == '0) ? ST_EXPIRE : ST_COUNT;
        end
        ST_COUNT: begin
          presc_clear = 1'b0;
          if (presc_tc) begin
            tick_d = 1'b1;
            if (rem_q != '0) rem_d = rem_q - 1'b1;
            if (rem_q <= VALUE_W'(1)) state_d = ST_EXPIRE;
          end
        end
        ST_EXPIRE: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    busy_d    = (state_d != ST_IDLE);
    expired_d = (state_d == ST_EXPIRE);
  end

  always_ff @(posedge clock or negedge systemResetN) begin
    if (!systemResetN) begin
      state_q   <= ST_IDLE;
      sel_q     <= INTERVAL_ARM_DELAY;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      expired_q <= expired_d;
    end
  end

  assign paramSel = sel_q;
  assign busy     = busy_q;
  assign tick     = tick_q;
  assign expired  = expired_q;

`ifdef TIMER_REMAINING_EN
  assign remaining = rem_q;
`endif

endmodule

// File: tb/tb_anti_theft_interval_timer.sv
// Self-checking bench for anti_theft_interval_timer (TICK_DIV=4): directed table, corner sequences, random vs model.
module tb_anti_theft_interval_timer;

  localparam int TICK_DIV = 4;
  localparam int VALUE_W  = 4;

  logic               clock = 1'b0;
  logic               systemResetN = 1'b0;
  logic               startTimer = 1'b0;
  logic [1:0]         intervalIn = 2'b00;
  logic [1:0]         paramSel;
  logic [VALUE_W-1:0] value;
  logic               busy, tick, expired;
`ifdef TIMER_REMAINING_EN
  logic [VALUE_W-1:0] remaining;
`endif

  logic [VALUE_W-1:0] store [4];
  assign value = store[paramSel];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  anti_theft_interval_timer #(
    .TICK_DIV(TICK_DIV),
    .VALUE_W (VALUE_W)
  ) dut (
    .clock       (clock),
    .systemResetN(systemResetN),
    .startTimer  (startTimer),
    .intervalIn  (intervalIn),
    .paramSel    (paramSel),
    .value       (value),
    .busy        (busy),
    .tick        (tick),
    .expired     (expired)
`ifdef TIMER_REMAINING_EN
    ,
    .remaining   (remaining)
`endif
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Issues a start for one cycle and follows the run until busy drops (bounded).
  // Offsets are cycles after the start cycle t.
  task automatic run_interval(input logic [1:0] iv, output int sel_seen, output int exp_at,
                              output int n_exp, output int ticks, output int idle_at);
    startTimer = 1'b1;
    intervalIn = iv;
    next_cycle();
    startTimer = 1'b0;
    sel_seen = int'(paramSel);
    exp_at = -1; n_exp = 0; ticks = 0; idle_at = -1;
    for (int k = 1; k <= 120; k++) begin
      if (k > 1) next_cycle();
      if (tick) ticks++;
      if (expired) begin
        n_exp++;
        if (exp_at < 0) exp_at = k;
      end
      if (!busy) begin
        idle_at = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0] iv;
    int         val;
    int         exp_expire;
    int         exp_ticks;
  } vec_t;

  vec_t vecs[5];

  int sel_seen, exp_at, n_exp, ticks, idle_at;

  // Reference model state for the random phase
  int         c, d, m_s, m_n, end_c;
  bit         m_active, fetch;
  logic [1:0] m_iv, m_sel;
  int         e_busy, e_tick, e_exp, e_rem;

  initial begin
    for (int i = 0; i < 4; i++) store[i] = '0;

    // Expire offset = 2 + N*TICK_DIV, one tick per second of N
    vecs[0] = '{iv: 2'b00, val: 6,  exp_expire: 26, exp_ticks: 6};
    vecs[1] = '{iv: 2'b10, val: 0,  exp_expire: 2,  exp_ticks: 0};
    vecs[2] = '{iv: 2'b01, val: 1,  exp_expire: 6,  exp_ticks: 1};
    vecs[3] = '{iv: 2'b11, val: 15, exp_expire: 62, exp_ticks: 15};
    vecs[4] = '{iv: 2'b10, val: 3,  exp_expire: 14, exp_ticks: 3};

    // Reset held for three cycles
    repeat (3) next_cycle();
    check("reset_busy", busy, 0);
    check("reset_tick", tick, 0);
    check("reset_expired", expired, 0);
    check("reset_paramSel", paramSel, 0);
    systemResetN = 1'b1;
    n_exp = 0;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      if (busy || expired || tick) n_exp++;
    end
    check("idle_no_activity", n_exp, 0);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      store[vecs[i].iv] = VALUE_W'(vecs[i].val);
      run_interval(vecs[i].iv, sel_seen, exp_at, n_exp, ticks, idle_at);
      check($sformatf("vec%0d_paramSel", i), sel_seen, int'(vecs[i].iv));
      check($sformatf("vec%0d_expire_at", i), exp_at, vecs[i].exp_expire);
      check($sformatf("vec%0d_expire_count", i), n_exp, 1);
      check($sformatf("vec%0d_ticks", i), ticks, vecs[i].exp_ticks);
      check($sformatf("vec%0d_idle_at", i), idle_at, vecs[i].exp_expire + 1);
      next_cycle();
    end

    // Reset in the middle of COUNT
    store[3] = 4'd10;
    startTimer = 1'b1; intervalIn = 2'b11;
    next_cycle();
    startTimer = 1'b0;
    repeat (8) next_cycle();
    check("midreset_busy_before", busy, 1);
    systemResetN = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_tick", tick, 0);
    check("midreset_expired", expired, 0);
    check("midreset_paramSel", paramSel, 0);
    repeat (2) next_cycle();
    systemResetN = 1'b1;
    n_exp = 0;
    for (int k = 0; k < 60; k++) begin
      next_cycle();
      if (expired || busy) n_exp++;
    end
    check("midreset_no_expire_after", n_exp, 0);

    // Restart 10 cycles into a run: only the second interval expires
    store[3] = 4'd10;
    store[1] = 4'd8;
    startTimer = 1'b1; intervalIn = 2'b11;
    next_cycle();
    startTimer = 1'b0;
    n_exp = 0;
    for (int k = 1; k < 10; k++) begin
      if (k > 1) next_cycle();
      if (expired) n_exp++;
    end
    next_cycle();
    check("restart_no_early_expire", n_exp, 0);
    run_interval(2'b01, sel_seen, exp_at, n_exp, ticks, idle_at);
    check("restart_paramSel", sel_seen, 1);
    check("restart_expire_at", exp_at, 34);
    check("restart_expire_count", n_exp, 1);
    check("restart_ticks", ticks, 8);
    next_cycle();

    // Reprogramming during COUNT is ignored; start during EXPIRE is honoured
    store[1] = 4'd8;
    startTimer = 1'b1; intervalIn = 2'b01;
    next_cycle();
    startTimer = 1'b0;
    ticks = 0; exp_at = -1;
    for (int k = 1; k <= 60 && exp_at < 0; k++) begin
      if (k > 1) next_cycle();
      if (k == 5) store[1] = 4'd2;
      if (tick) ticks++;
      if (expired) exp_at = k;
    end
    check("reprog_ticks", ticks, 8);
    check("reprog_expire_at", exp_at, 34);
    store[2] = 4'd0;
    startTimer = 1'b1; intervalIn = 2'b10;
    next_cycle();
    startTimer = 1'b0;
    check("expire_start_busy", busy, 1);
    check("expire_start_expired", expired, 0);
    check("expire_start_paramSel", paramSel, 2);
    next_cycle();
    check("expire_start_second_expire", expired, 1);
    next_cycle();
    check("expire_start_idle", busy, 0);

    // Random phase against the timeline model; reset first to a known paramSel
    systemResetN = 1'b0;
    repeat (2) next_cycle();
    systemResetN = 1'b1;
    c = 0; m_s = 0; m_n = 0; m_active = 1'b0; m_iv = 2'b00; m_sel = 2'b00;
    for (int i = 0; i < 4; i++) store[i] = VALUE_W'($urandom_range(0, 5));
    for (int it = 0; it < 1500; it++) begin
      next_cycle();
      c++;
      d = c - m_s;
      e_busy = 0; e_tick = 0; e_exp = 0; e_rem = 0; fetch = 1'b0;
      if (m_active) begin
        if (d == 1) begin
          e_busy = 1;
          fetch  = 1'b1;
        end else begin
          end_c = 2 + TICK_DIV * m_n;
          if (d <= end_c) begin
            e_busy = 1;
            e_exp  = (d == end_c) ? 1 : 0;
            e_tick = (d >= 2 + TICK_DIV && (d - 2) % TICK_DIV == 0) ? 1 : 0;
            e_rem  = m_n - (d - 2) / TICK_DIV;
          end else begin
            m_active = 1'b0;
          end
        end
      end
      check("rand_busy", busy, e_busy);
      check("rand_tick", tick, e_tick);
      check("rand_expired", expired, e_exp);
      check("rand_paramSel", paramSel, int'(m_sel));
`ifdef TIMER_REMAINING_EN
      if (!fetch) check("rand_remaining", remaining, e_rem);
`endif

      if ($urandom_range(0, 15) == 0) store[$urandom_range(0, 3)] = VALUE_W'($urandom_range(0, 5));
      startTimer = ($urandom_range(0, 19) == 0);
      intervalIn = 2'($urandom_range(0, 3));
      if (m_active && d == 1) m_n = int'(store[m_iv]);
      if (startTimer) begin
        m_s      = c;
        m_iv     = intervalIn;
        m_sel    = intervalIn;
        m_active = 1'b1;
      end
    end
    startTimer = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
